mux_pkt_arbiter: RTL
====================

# mux_pkt_arbiter

Packet-level round-robin arbiter that drives the select of the 2:1 router output mux (`mux`). It watches the flit type and valid of both input ports and locks the mux onto one port from a HEAD flit through the matching TAIL flit, so packets never interleave. It issues per-port grants to the upstream sources and honours downstream backpressure. A length watchdog forces release if a TAIL never arrives.

## Interface
- `MAXLEN`, 64: flits accepted in one lock, HEAD and TAIL included, before forced release; must be ≥ 2.
- `CNTW`, 7: width of the flit counter; must satisfy 2^CNTW > MAXLEN.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ivalid_0`  in  1  port 0 flit valid.
- `itype_0`  in  2  port 0 flit type: NONE=00, HEAD=01, DATA=10, TAIL=11.
- `ivalid_1`  in  1  port 1 flit valid.
- `itype_1`  in  2  port 1 flit type, same encoding as `itype_0`.
- `oready`  in  1  downstream can accept a flit this cycle.
- `sel`  out  1  mux select (0 = port 0, 1 = port 1); registered.
- `grant_0`  out  1  port 0 may transfer this cycle.
- `grant_1`  out  1  port 1 may transfer this cycle.
- `busy`  out  1  a port holds the lock.
- `err`  out  1  one-cycle pulse on watchdog release.
- `flit_cnt`  out  CNTW  flits accepted in the current lock.

## Operation
- FSM states: IDLE, LOCK0, LOCK1. `sel` = 1 only in LOCK1 and is otherwise 0. `busy` = (state ≠ IDLE).
- Round-robin pointer `prio`, 1 bit.
- In IDLE, a HEAD is a valid flit with type HEAD.
  - Only port x has a HEAD: go to LOCKx.
  - Both ports have a HEAD: go to LOCK[prio].
  - Neither: stay in IDLE.
- Non-HEAD valid flits in IDLE are ignored. No grant is issued, and the source stalls.
- `grant_x` = (state == LOCKx) & `oready`. It is combinational from state and `oready`. The non-owner grant is always 0.
- A transfer (fire) occurs when `ivalid_x` & `grant_x`. Sources hold flit and valid until they fire.
- On each fire in LOCKx, `flit_cnt` increments.
- A fire carrying type TAIL, or a fire that brings `flit_cnt` to MAXLEN:
  - state → IDLE
  - `prio` ← ~x
  - `flit_cnt` ← 0
- If the release came from the watchdog with a non-TAIL flit, `err` = 1 for one cycle.
- A TAIL fire that is also the MAXLEN-th fire counts as a normal TAIL release: no `err`.
- HEAD or NONE types received mid-lock are forwarded and counted. They do not change state.
- When `oready` = 0, grants are low, nothing fires, and state and `flit_cnt` hold.
- If the owner's `ivalid` drops mid-packet, the lock holds indefinitely. The watchdog counts fires, not cycles.

## Timing
- Reset values:
  - state = IDLE, `prio` = 0, `flit_cnt` = 0
  - `sel` = 0, `busy` = 0, `err` = 0
  - `grant_0` = `grant_1` = 0
- `rst` mid-lock: the lock is abandoned. All outputs are at reset values in the cycle after the edge, and no `err` pulses.
- Arbitration latency: a HEAD presented in IDLE at cycle t gives state, `sel` and `busy` at t+1. The first fire is possible at t+1.
- Release: a TAIL fire at cycle t gives IDLE at t+1. The next lock starts at t+2 at the earliest, so there is one bubble cycle between packets.
- `err` is asserted in the cycle after the forcing fire, together with IDLE.
- `flit_cnt` shows the count after the fire on the following cycle.

## Structure
- Shared package `noc_pkg`:
  - flit type localparams `TYPE_NONE`/`TYPE_HEAD`/`TYPE_DATA`/`TYPE_TAIL` (2-bit)
  - the FSM state encoding (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2)
- Sub-module `rr_pick2` (combinational): inputs `req[1:0]` and `prio`, outputs winner index and `any`. It is reused by later N-port arbiters.
- The top level holds the FSM, `prio`, the counter, and the `err` register.

## Test plan
- Port 1 only:
  - Stimulus: HEAD at cycle 2, 20 DATA, then TAIL, `oready` = 1.
  - Response: `sel` = 1 and `grant_1` = 1 from cycle 3. 22 fires on cycles 3–24. IDLE at cycle 25. `prio` = 0.
- Simultaneous HEADs:
  - Stimulus: HEADs on both ports at cycle 2, 3-flit packets.
  - Response: port 0 is granted cycles 3–5. IDLE at 6. Port 1 is locked at 7 and granted 7–9. `grant_0` is never high while `sel` = 1.
- Backpressure:
  - Stimulus: lock on port 0, drop `oready` for cycles 5–7.
  - Response: `grant_0` = 0 and `flit_cnt` frozen during cycles 5–7. Transfer resumes at cycle 8 with no lost or extra counts.
- Watchdog:
  - Stimulus: `MAXLEN` = 8, port 0 sends HEAD then DATA continuously.
  - Response: after the 8th fire, the next cycle shows IDLE, `err` = 1 for exactly one cycle, and `prio` = 1.
- Reset mid-packet:
  - Stimulus: assert `rst` after the 5th fire in LOCK1.
  - Response: the next cycle shows IDLE, `sel` = 0, `flit_cnt` = 0, `prio` = 0, and no `err`.
- Stray DATA:
  - Stimulus: DATA valid on port 1 while IDLE.
  - Response: no grant and state remains IDLE.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes and the packet arbiter state encoding.
package noc_pkg;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick, purely combinational: prio breaks ties.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       any
);

  assign any = |req;

  always_comb begin
    winner = 1'b0;
    if (req[0] && req[1]) begin
      winner = prio;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/mux_pkt_arbiter.sv
// Packet-locking round-robin arbiter for the 2:1 router mux; lock visible one cycle after HEAD.
// Grants follow oready combinationally, so backpressure freezes state and count in place.
module mux_pkt_arbiter
  import noc_pkg::*;
#(
  parameter int MAXLEN = 64,
  parameter int CNTW   = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ivalid_0,
  input  logic [1:0]      itype_0,
  input  logic            ivalid_1,
  input  logic [1:0]      itype_1,
  input  logic            oready,
  output logic            sel,
  output logic            grant_0,
  output logic            grant_1,
  output logic            busy,
  output logic            err,
  output logic [CNTW-1:0] flit_cnt
);

  arb_state_e      state_q;
  logic            prio_q;
  logic            sel_q;
  logic            busy_q;
  logic            err_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  logic [1:0] head_req;
  logic       pick_win;
  logic       pick_any;
  logic       own_port;
  logic [1:0] own_type;
  logic       own_tail;
  logic       fire;
  logic       pkt_done;

  assign head_req[0] = ivalid_0 && (itype_0 == TYPE_HEAD);
  assign head_req[1] = ivalid_1 && (itype_1 == TYPE_HEAD);

  rr_pick2 u_pick (
    .req    (head_req),
    .prio   (prio_q),
    .winner (pick_win),
    .any    (pick_any)
  );

  assign grant_0 = (state_q == ST_LOCK0) && oready;
  assign grant_1 = (state_q == ST_LOCK1) && oready;

  assign own_port = (state_q == ST_LOCK1);
  assign own_type = own_port ? itype_1 : itype_0;
  assign own_tail = (own_type == TYPE_TAIL);
  assign fire     = (grant_0 && ivalid_0) || (grant_1 && ivalid_1);
  assign cnt_d    = cnt_q + CNTW'(1);

  // The watchdog counts accepted flits, so a stalled owner can hold the lock forever.
  assign pkt_done = fire && (own_tail || (cnt_d == CNTW'(MAXLEN)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q <= pick_win ? ST_LOCK1 : ST_LOCK0;
            sel_q   <= pick_win;
            busy_q  <= 1'b1;
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          if (pkt_done) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            prio_q  <= ~own_port;
            cnt_q   <= '0;
            err_q   <= ~own_tail;
          end else if (fire) begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sel      = sel_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign flit_cnt = cnt_q;

endmodule
